stage2_pow2_approx: RTL

Second stage of the tree-based softmax approximation. It sits directly downstream of the log2 stage and consumes its `o_valid`, `o_log2_in0` and bypass outputs. For each valid sample it computes `y = x − log2(sum)` in fixed point, then approximates `2^y` with a shift-based mantissa/exponent method. The result is the normalized softmax term in unsigned Q6.10. The block is a 3-stage pipeline with a global enable, matching the stall behaviour of the upstream stage.

---
 rtl/softmax_approx_pkg.sv | 21 ++
 rtl/pow2_shifter.sv | 31 +++
 rtl/stage2_pow2_approx.sv | 108 ++++++++++
 3 files changed

// File: rtl/softmax_approx_pkg.sv
// Shared fixed-point formats, constants and classification enum for the softmax approximation tree.
package softmax_approx_pkg;

  localparam int Q_FRAC_BITS = 10;
  localparam int DATA_W      = 16;
  localparam int EXP_W       = DATA_W + 1 - Q_FRAC_BITS;

  localparam logic [DATA_W-1:0] LOG2_ZERO_SENTINEL = 16'h8000;
  localparam logic [DATA_W-1:0] POW2_SAT_VAL       = 16'hFFFF;

  // Exponent bounds: at or above SAT the result no longer fits, at or below ZERO it truncates to 0.
  localparam logic signed [EXP_W-1:0] POW2_E_SAT  = 7'sd6;
  localparam logic signed [EXP_W-1:0] POW2_E_ZERO = -7'sd11;

  typedef enum logic [1:0] {
    NORM,
    SAT,
    ZERO
  } pow2_class_t;

endpackage

// File: rtl/pow2_shifter.sv
// Combinational 2^(e+f) approximation: mantissa {1,f} shifted by the signed exponent e.
module pow2_shifter
  import softmax_approx_pkg::*;
(
  input  pow2_class_t                  cls,
  input  logic signed [EXP_W-1:0]      e,
  input  logic        [Q_FRAC_BITS-1:0] f,
  output logic        [DATA_W-1:0]     result
);

  logic [DATA_W-1:0] mant;
  logic [EXP_W-1:0]  neg_e;

  assign mant  = {{(DATA_W-Q_FRAC_BITS-1){1'b0}}, 1'b1, f};
  assign neg_e = -e;

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    result = '0;
    case (cls)
      SAT:     result = POW2_SAT_VAL;
      ZERO:    result = '0;
      default: begin
        // NORM guarantees e in [-10, 5], so the low shift-amount bits are sufficient.
        if (e >= 0) result = mant << e[2:0];
        else        result = mant >> neg_e[3:0];
      end
    endcase
  end

endmodule

// File: rtl/stage2_pow2_approx.sv
// Softmax stage 2: 3-stage pipeline computing 2^(x - log2_sum) in unsigned Q6.10.
// Optional zero-sum sentinel detection with o_err/o_err_cnt under STAGE2_ZERO_GUARD_EN.
module stage2_pow2_approx
  import softmax_approx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_log2_sum,
  input  logic [DATA_W-1:0] i_x,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_pow2,
  output logic [DATA_W-1:0] o_x_byp
`ifdef STAGE2_ZERO_GUARD_EN
  ,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
`endif
);

  // Stage 0 registers
  logic              s0_valid;
  logic [DATA_W-1:0] s0_x;
  logic [DATA_W-1:0] s0_log2;

  // Stage 1 registers
  logic                   s1_valid;
  logic [DATA_W-1:0]      s1_x;
  pow2_class_t            s1_cls;
  logic signed [EXP_W-1:0] s1_e;
  logic [Q_FRAC_BITS-1:0] s1_f;

  logic [DATA_W:0]         diff;
  logic signed [EXP_W-1:0] diff_e;
  pow2_class_t             diff_cls;
  logic [DATA_W-1:0]       shift_res;

  // Floor semantics fall out of two's complement: the top bits are floor(diff), the low bits stay positive.
  assign diff   = {s0_x[DATA_W-1], s0_x} - {s0_log2[DATA_W-1], s0_log2};
  assign diff_e = diff[DATA_W:Q_FRAC_BITS];

`ifdef STAGE2_ZERO_GUARD_EN
  logic s0_sentinel;
  logic s1_err;
  assign s0_sentinel = (s0_log2 == LOG2_ZERO_SENTINEL);
`endif

  always_comb begin
    diff_cls = NORM;
`ifdef STAGE2_ZERO_GUARD_EN
    if (s0_sentinel)                diff_cls = ZERO;
    else
`endif
    if (diff_e >= POW2_E_SAT)       diff_cls = SAT;
    else if (diff_e <= POW2_E_ZERO) diff_cls = ZERO;
  end

  pow2_shifter u_shifter (
    .cls    (s1_cls),
    .e      (s1_e),
    .f      (s1_f),
    .result (shift_res)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s0_valid  <= 1'b0;
      s0_x      <= '0;
      s0_log2   <= '0;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_cls    <= NORM;
      s1_e      <= '0;
      s1_f      <= '0;
      o_valid   <= 1'b0;
      o_pow2    <= '0;
      o_x_byp   <= '0;
`ifdef STAGE2_ZERO_GUARD_EN
      s1_err    <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
`endif
    end else if (i_en) begin
      // NOTE: non-blocking assignments make every stage read the previous-cycle value of the one before it.
      s0_valid <= i_valid;
      s0_x     <= i_x;
      s0_log2  <= i_log2_sum;

      s1_valid <= s0_valid;
      s1_x     <= s0_x;
      s1_cls   <= diff_cls;
      s1_e     <= diff_e;
      s1_f     <= diff[Q_FRAC_BITS-1:0];

      o_valid  <= s1_valid;
      o_pow2   <= shift_res;
      o_x_byp  <= s1_x;
`ifdef STAGE2_ZERO_GUARD_EN
      s1_err   <= s0_valid && s0_sentinel;
      o_err    <= s1_valid && s1_err;
      if (s1_valid && s1_err && (o_err_cnt != 8'hFF))
        o_err_cnt <= o_err_cnt + 8'd1;
`endif
    end
  end

endmodule
